// File: rtl/fp_posit_pkg.sv
// Shared FP16 format constants and the converter FSM state encoding.
package fp_posit_pkg;

    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;
    localparam int FP16_BIAS  = 15;
    localparam int FP16_EMAX  = (1 << FP16_EXP_W) - 1;

    localparam logic [15:0] FP16_INF = 16'h7C00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/acc_to_fp16_if.sv
// Handshake bundle between the MAC (producer), the converter and its consumer.
interface acc_to_fp16_if #(
    parameter int ACC_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ACC_WIDTH-1:0] acc_in;
    logic [4:0]           exp_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          fp_out;
    logic                 ovf;
    logic                 unf;

    modport master (
        output in_valid, acc_in, exp_in, out_ready,
        input  in_ready, out_valid, fp_out, ovf, unf
    );

    modport slave (
        input  in_valid, acc_in, exp_in, out_ready,
        output in_ready, out_valid, fp_out, ovf, unf
    );
endinterface

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even and packing of a normalised magnitude into binary16,
// including flush-to-zero and saturation to infinity.
module fp16_round_pack
    import fp_posit_pkg::*;
#(
    parameter int ACC_WIDTH = 32
) (
    input  logic                 sign,
    input  logic signed [7:0]    e_pre,
    input  logic [ACC_WIDTH-1:0] mag,
    output logic [15:0]          fp_out,
    output logic                 ovf,
    output logic                 unf
);

    logic [FP16_MAN_W-1:0] mant;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic [FP16_MAN_W:0]   mant_r;
    logic signed [8:0]     e_post;

    always_comb begin
        mant     = mag[ACC_WIDTH-2 -: FP16_MAN_W];
        guard    = mag[ACC_WIDTH-2-FP16_MAN_W];
        sticky   = |mag[ACC_WIDTH-3-FP16_MAN_W:0];
        round_up = guard & (sticky | mant[0]);
        // A carry out of the mantissa leaves mant_r[9:0] at zero and bumps the exponent.
        mant_r   = {1'b0, mant} + {{FP16_MAN_W{1'b0}}, round_up};
        e_post   = {e_pre[7], e_pre} + {8'b0, mant_r[FP16_MAN_W]};

        fp_out = '0;
        ovf    = 1'b0;
        unf    = 1'b0;
        if (mag == '0) begin
            fp_out = '0;
        end else if (e_pre <= 8'sd0) begin
            fp_out = {sign, 15'b0};
            unf    = 1'b1;
        end else if (e_post >= 9'(FP16_EMAX)) begin
            fp_out = {sign, FP16_INF[14:0]};
            ovf    = 1'b1;
        end else begin
            fp_out = {sign, e_post[FP16_EXP_W-1:0], mant_r[FP16_MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/acc_to_fp16.sv
// Converts a two's-complement MAC accumulator with block exponent into IEEE binary16
// using a bit-serial normaliser (one shift per cycle) and a combinational round/pack stage.
module acc_to_fp16
    import fp_posit_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int LSB_OFFSET = 10
) (
    input  logic          clk,
    input  logic          rst,
    acc_to_fp16_if.slave  bus
);

    localparam int SW = $clog2(ACC_WIDTH);

    state_t state_q, state_d;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] mag_q, mag_d;
    logic [4:0]           exp_q, exp_d;
    logic                 sign_q, sign_d;
    logic [SW-1:0]        s_q, s_d;
    logic [15:0]          fp_q, fp_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic                 in_ready;
    logic                 out_valid;
    logic                 accept;
    logic signed [7:0]    e_pre;
    logic [15:0]          rp_fp;
    logic                 rp_ovf;
    logic                 rp_unf;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ABS;
            ST_ABS:   state_d = (acc_q == '0) ? ST_ROUND : ST_NORM;
            ST_NORM:  if (mag_q[ACC_WIDTH-1]) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_OUT;
            ST_OUT:   if (bus.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_OUT);
    end

    assign accept = bus.in_valid & in_ready;

    // Leading-one position is W-1-s once the magnitude is normalised.
    assign e_pre = 8'((ACC_WIDTH - 1 - int'(s_q)) + int'(exp_q) - LSB_OFFSET);

    fp16_round_pack #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_round_pack (
        .sign   (sign_q),
        .e_pre  (e_pre),
        .mag    (mag_q),
        .fp_out (rp_fp),
        .ovf    (rp_ovf),
        .unf    (rp_unf)
    );

    always_comb begin
        acc_d  = acc_q;
        exp_d  = exp_q;
        sign_d = sign_q;
        mag_d  = mag_q;
        s_d    = s_q;
        fp_d   = fp_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d = bus.acc_in;
                    exp_d = bus.exp_in;
                    s_d   = '0;
                end
            end
            ST_ABS: begin
                // Negating -2^(W-1) wraps back to 2^(W-1), which is the correct unsigned magnitude.
                sign_d = acc_q[ACC_WIDTH-1];
                mag_d  = acc_q[ACC_WIDTH-1] ? (~acc_q + ACC_WIDTH'(1)) : acc_q;
            end
            ST_NORM: begin
                if (!mag_q[ACC_WIDTH-1]) begin
                    mag_d = mag_q << 1;
                    s_d   = s_q + SW'(1);
                end
            end
            ST_ROUND: begin
                fp_d  = rp_fp;
                ovf_d = rp_ovf;
                unf_d = rp_unf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        acc_q  <= acc_d;
        exp_q  <= exp_d;
        sign_q <= sign_d;
        mag_q  <= mag_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            fp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            fp_q  <= fp_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.fp_out    = fp_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;

endmodule

// File: doc/acc_to_fp16.md
ACC_TO_FP16 -- requirements
Module: acc_to_fp16

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: accumulator width W.
REQ-002 SHALL have parameter LSB_OFFSET, default 10: acc LSB weight is 2^(exp_in-15-LSB_OFFSET).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  acc_in/exp_in valid; this is the MAC done pulse.
REQ-006 SHALL have port in_ready  output  1  high only in IDLE.
REQ-007 SHALL have port acc_in  input  W  two's-complement MAC fixed_point_out.
REQ-008 SHALL have port exp_in  input  5  MAC exp_out, FP16-biased block exponent.
REQ-009 SHALL have port out_valid  output  1  fp_out/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts.
REQ-011 SHALL have port fp_out  output  16  IEEE binary16 result.
REQ-012 SHALL have port ovf  output  1  result saturated to infinity.
REQ-013 SHALL have port unf  output  1  nonzero result flushed to zero.

Function
REQ-014 SHALL accept on the rising edge where in_valid&in_ready and capture acc_in, exp_in.
REQ-015 SHALL use FSM IDLE->ABS->NORM->ROUND->OUT->IDLE, with ABS->ROUND when the magnitude is zero.
REQ-016 ABS (1 cycle) SHALL latch the sign and magnitude |acc| as a W-bit unsigned value (-2^(W-1) -> 2^(W-1)).
REQ-017 NORM SHALL left-shift the magnitude one bit per cycle with counter s++ while mag[W-1]==0, and move to ROUND on the edge where mag[W-1]==1; leading-one position p=W-1-s.
REQ-018 ROUND SHALL compute the pre-round biased exponent E=p+exp_in-LSB_OFFSET (signed, 8 bits), mantissa=mag[W-2:W-11], guard=mag[W-12], sticky=OR(mag[W-13:0]).
REQ-019 ROUND SHALL round to nearest even: increment when guard&(sticky|mant[0]); a mantissa carry-out SHALL zero the mantissa and give E+1.
REQ-020 SHALL flush when pre-round E<=0: fp_out={sign,15'b0}, unf=1; no subnormals.
REQ-021 SHALL saturate when post-round E>=31: fp_out={sign,5'h1F,10'h0}, ovf=1.
REQ-022 Zero magnitude SHALL give fp_out=16'h0000, ovf=unf=0.
REQ-023 Latency, accept edge to out_valid visible: W+2-p edges for a nonzero input (3 for p=W-1); 2 edges for zero.
REQ-024 In OUT, out_valid=1, and fp_out/ovf/unf SHALL hold stable until the out_ready edge; then go to IDLE.
REQ-025 SHALL NOT accept input in the same cycle as an output handshake; in_ready rises the cycle after.
REQ-026 in_valid while busy SHALL be ignored; the MAC must hold done until in_ready.

Reset
REQ-027 rst=1 on an edge SHALL force IDLE, out_valid=0, fp_out=0, ovf=0, unf=0, s=0, and in_ready=1 after release.
REQ-028 Reset mid-NORM or mid-OUT SHALL discard the pending result with no output handshake.

Structure
REQ-029 Package fp_posit_pkg SHALL hold the FP16 widths (exp 5, man 10), BIAS=15, the FP16_INF constant, and the FSM state enum.
REQ-030 Combinational sub-module fp16_round_pack SHALL take (sign, E, mag) and produce (fp_out, ovf, unf); the FSM, shifter and counter stay in acc_to_fp16.

Verification
REQ-031 acc_in=0x0000103D, exp_in=16 -> fp_out=0x480F, flags 0, out_valid 22 edges after accept.
REQ-032 acc_in=0x00000400, exp_in=15 -> 0x3C00; acc_in=0xFFFFFC00, exp_in=15 -> 0xBC00.
REQ-033 RNE: acc_in=0x801, exp_in=10 -> 0x2C00 (tie to even); acc_in=0x803, exp_in=10 -> 0x2C02.
REQ-034 acc_in=0x7FFFFFFF, exp_in=15 -> 0x7C00 with ovf=1; acc_in=1, exp_in=0 -> 0x0000 with unf=1; acc_in=0 -> 0x0000 after 2 edges.
REQ-035 Hold out_ready=0 for 5 cycles -> fp_out stable and in_ready=0 throughout; in_valid pulsed mid-NORM -> ignored.
REQ-036 Assert rst mid-NORM -> next cycle out_valid=0 and in_ready=1; a following accept converts correctly.
